cfo_sweep_ctrl: RTL and testbench

Programmable carrier-frequency-offset sweep controller for the MSK modem channel model. Holds a small table of phase-increment/dwell pairs and steps through them, driving the phase-increment word of the downstream complex rotator (NCO plus I/Q mixer) that applies CFO to the transmit samples. Lets one simulation or bench run cover a sequence of offsets, including frequency jumps and slow drifts, for carrier-recovery testing, without reconfiguring the rotator by hand.

---
 rtl/cfo_sweep_ctrl_if.sv | 28 ++
 rtl/cfo_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_cfo_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfo_sweep_ctrl_if.sv
// Configuration write port for the CFO sweep table.
// The controller takes the slave side; whoever programs the table drives the master side.
interface cfo_sweep_ctrl_if #(
    parameter int unsigned PINC_W    = 32,
    parameter int unsigned DWELL_W   = 24,
    parameter int unsigned N_ENTRIES = 8
);
    localparam int unsigned ADDR_W = $clog2(N_ENTRIES);

    logic                     cfg_we;
    logic [ADDR_W-1:0]        cfg_addr;
    logic signed [PINC_W-1:0] cfg_pinc;
    logic [DWELL_W-1:0]       cfg_dwell;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_pinc,
        output cfg_dwell
    );

    modport slave (
        input cfg_we,
        input cfg_addr,
        input cfg_pinc,
        input cfg_dwell
    );
endinterface

// File: rtl/cfo_sweep_ctrl.sv
// Carrier-frequency-offset sweep controller: steps the rotator phase increment through a table.
// Build option CFO_SWEEP_RAMP_EN inserts a linear ramp of 2^RAMP_SHIFT cycles before each dwell.
module cfo_sweep_ctrl #(
    parameter int unsigned PINC_W     = 32,
    parameter int unsigned DWELL_W    = 24,
    parameter int unsigned N_ENTRIES  = 8,
    parameter int unsigned RAMP_SHIFT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    cfo_sweep_ctrl_if.slave                cfg,
    input  logic [$clog2(N_ENTRIES):0]     num_entries,
    input  logic                           loop_en,
    input  logic                           start,
    input  logic                           abort,
    output logic signed [PINC_W-1:0]       pinc_out,
    output logic                           pinc_vld,
    output logic [$clog2(N_ENTRIES)-1:0]   entry_idx,
    output logic                           busy,
    output logic                           done
);
    localparam int unsigned ADDR_W = $clog2(N_ENTRIES);
    localparam int unsigned NUM_W  = ADDR_W + 1;

    if (RAMP_SHIFT >= PINC_W) begin : g_ramp_shift_chk
        $error("RAMP_SHIFT must be smaller than PINC_W");
    end
    if ((1 << ADDR_W) != N_ENTRIES) begin : g_depth_chk
        $error("N_ENTRIES must be a power of two");
    end

    typedef struct packed {
        logic signed [PINC_W-1:0] pinc;
        logic [DWELL_W-1:0]       dwell;
    } entry_t;

`ifdef CFO_SWEEP_RAMP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int unsigned RC_W     = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
    localparam int unsigned RAMP_LEN = 1 << RAMP_SHIFT;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_e;
`endif

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]       cnt_q, cnt_d;
    logic [NUM_W-1:0]         num_q, num_d;
    logic signed [PINC_W-1:0] pinc_q, pinc_d;
    logic                     vld_q, vld_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    entry_t                   tbl_q [N_ENTRIES];
    entry_t                   tbl_d [N_ENTRIES];

`ifdef CFO_SWEEP_RAMP_EN
    logic signed [PINC_W-1:0] target_q, target_d;
    logic signed [PINC_W-1:0] step_q, step_d;
    logic [RC_W-1:0]          rcnt_q, rcnt_d;
    logic signed [PINC_W-1:0] diff_c;
    logic signed [PINC_W-1:0] ramp_step_c;
`endif

    logic [NUM_W-1:0]         num_c;
    logic                     last_c;
    logic [ADDR_W-1:0]        nxt_idx_c;
    logic [ADDR_W-1:0]        load_idx_c;
    entry_t                   load_ent_c;
    logic                     load_c;

    // Requests beyond the table depth run the whole table.
    assign num_c      = (num_entries > NUM_W'(N_ENTRIES)) ? NUM_W'(N_ENTRIES) : num_entries;
    assign last_c     = (NUM_W'(idx_q) == (num_q - NUM_W'(1)));
    assign nxt_idx_c  = last_c ? '0 : (idx_q + ADDR_W'(1));
    assign load_idx_c = (state_q == S_IDLE) ? '0 : nxt_idx_c;
    assign load_ent_c = tbl_q[load_idx_c];

`ifdef CFO_SWEEP_RAMP_EN
    assign diff_c      = load_ent_c.pinc - pinc_q;
    assign ramp_step_c = diff_c >>> RAMP_SHIFT;
`endif

    // Table is writable only while idle so a running sweep never sees a half-updated entry.
    always_comb begin : tbl_next
        tbl_d = tbl_q;
        if (cfg.cfg_we && (state_q == S_IDLE)) begin
            tbl_d[cfg.cfg_addr] = '{pinc: cfg.cfg_pinc, dwell: cfg.cfg_dwell};
        end
    end

    always_ff @(posedge clk) begin : tbl_reg
        tbl_q <= tbl_d;
    end

    always_comb begin : fsm_next
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        pinc_d  = pinc_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        load_c  = 1'b0;
`ifdef CFO_SWEEP_RAMP_EN
        target_d = target_q;
        step_d   = step_q;
        rcnt_d   = rcnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_c == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        num_d  = num_c;
                        busy_d = 1'b1;
                        load_c = 1'b1;
                    end
                end
            end
`ifdef CFO_SWEEP_RAMP_EN
            S_RAMP: begin
                if (rcnt_q == '0) begin
                    state_d = S_DWELL;
                end else begin
                    vld_d  = 1'b1;
                    rcnt_d = rcnt_q - RC_W'(1);
                    // Last ramp step lands exactly on the target, dropping shift residue.
                    pinc_d = (rcnt_q == RC_W'(1)) ? target_q : (pinc_q + step_q);
                end
            end
`endif
            S_DWELL: begin
                if (cnt_q > DWELL_W'(1)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!last_c || loop_en) begin
                    load_c = 1'b1;
                end else begin
                    state_d = S_DONE;
                    pinc_d  = '0;
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entry load is shared by sweep start, normal advance and loop wrap.
        if (load_c) begin
            idx_d = load_idx_c;
            cnt_d = (load_ent_c.dwell == '0) ? DWELL_W'(1) : load_ent_c.dwell;
`ifdef CFO_SWEEP_RAMP_EN
            target_d = load_ent_c.pinc;
            step_d   = ramp_step_c;
            pinc_d   = pinc_q + ramp_step_c;
            rcnt_d   = RC_W'(RAMP_LEN - 1);
            vld_d    = 1'b1;
            state_d  = S_RAMP;
`else
            pinc_d  = load_ent_c.pinc;
            vld_d   = (load_ent_c.pinc != pinc_q);
            state_d = S_DWELL;
`endif
        end

        if (abort && busy_q) begin
            state_d = S_IDLE;
            pinc_d  = '0;
            vld_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            num_q    <= '0;
            pinc_q   <= '0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CFO_SWEEP_RAMP_EN
            target_q <= '0;
            step_q   <= '0;
            rcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            pinc_q   <= pinc_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CFO_SWEEP_RAMP_EN
            target_q <= target_d;
            step_q   <= step_d;
            rcnt_q   <= rcnt_d;
`endif
        end
    end

    assign pinc_out  = pinc_q;
    assign pinc_vld  = vld_q;
    assign entry_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cfo_sweep_ctrl.sv
// Directed bench for cfo_sweep_ctrl; expectations are hand-derived sweep timelines.
// With CFO_SWEEP_RAMP_EN defined the ramp timelines replace the step-build ones.
`timescale 1ns/1ps
module tb_cfo_sweep_ctrl;
    localparam int unsigned PINC_W     = 32;
    localparam int unsigned DWELL_W    = 24;
    localparam int unsigned N_ENTRIES  = 8;
    localparam int unsigned RAMP_SHIFT = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         num_entries;
    logic               loop_en;
    logic               start;
    logic               abort;
    logic signed [31:0] pinc_out;
    logic               pinc_vld;
    logic [2:0]         entry_idx;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

`ifdef CFO_SWEEP_RAMP_EN
    logic [31:0] ramp1_exp [8]  = '{32'd25, 32'd50, 32'd75, 32'd100, 32'd100, 32'd100, 32'd100, 32'd0};
    logic [31:0] ramp2_exp [13] = '{32'd25, 32'd50, 32'd75, 32'd100, 32'd100, 32'd100, 32'd100,
                                    32'd100, 32'd100, 32'd100, 32'd103, 32'd103, 32'd0};
`endif

    cfo_sweep_ctrl_if #(.PINC_W(PINC_W), .DWELL_W(DWELL_W), .N_ENTRIES(N_ENTRIES)) cfg_bus ();

    cfo_sweep_ctrl #(
        .PINC_W    (PINC_W),
        .DWELL_W   (DWELL_W),
        .N_ENTRIES (N_ENTRIES),
        .RAMP_SHIFT(RAMP_SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg        (cfg_bus),
        .num_entries(num_entries),
        .loop_en    (loop_en),
        .start      (start),
        .abort      (abort),
        .pinc_out   (pinc_out),
        .pinc_vld   (pinc_vld),
        .entry_idx  (entry_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] p, input logic [23:0] d);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_pinc  = p;
        cfg_bus.cfg_dwell = d;
        step();
        cfg_bus.cfg_we    = 1'b0;
    endtask

    task automatic go(input logic [3:0] n, input logic lp);
        num_entries = n;
        loop_en     = lp;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    initial begin
        logic [31:0] ep;
        reset             = 1'b1;
        num_entries       = '0;
        loop_en           = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_pinc  = '0;
        cfg_bus.cfg_dwell = '0;
        step();
        step();
        chk("rst.pinc", pinc_out, 32'd0);
        chk("rst.vld",  32'(pinc_vld), 32'd0);
        chk("rst.idx",  32'(entry_idx), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

`ifdef CFO_SWEEP_RAMP_EN
        // Single entry 100/3: four ramp cycles then three dwell cycles at target.
        wr(3'd0, 32'd100, 24'd3);
        wr(3'd1, 32'd103, 24'd1);
        go(4'd1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ramp1.pinc@%0d", i), pinc_out, ramp1_exp[i-1]);
            chk($sformatf("ramp1.vld@%0d", i), 32'(pinc_vld), (i <= 4 || i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("ramp1.done@%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
            step();
        end
        // 100 -> 103 has a zero step, so the value only snaps on the last ramp cycle.
        go(4'd2, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            chk($sformatf("ramp2.pinc@%0d", i), pinc_out, ramp2_exp[i-1]);
            chk($sformatf("ramp2.done@%0d", i), 32'(done), (i == 13) ? 32'd1 : 32'd0);
            step();
        end
`else
        // Three-entry step sweep ending on the largest positive increment.
        wr(3'd0, 32'd1000, 24'd5);
        wr(3'd1, 32'(-2000), 24'd3);
        wr(3'd2, 32'h7FFF_FFFF, 24'd1);
        go(4'd3, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            if (i <= 5)       ep = 32'd1000;
            else if (i <= 8)  ep = 32'(-2000);
            else if (i == 9)  ep = 32'h7FFF_FFFF;
            else              ep = 32'd0;
            chk($sformatf("sweep.pinc@%0d", i), pinc_out, ep);
            chk($sformatf("sweep.vld@%0d", i), 32'(pinc_vld),
                (i == 1 || i == 6 || i == 9 || i == 10) ? 32'd1 : 32'd0);
            chk($sformatf("sweep.done@%0d", i), 32'(done), (i == 10) ? 32'd1 : 32'd0);
            chk($sformatf("sweep.busy@%0d", i), 32'(busy), (i <= 9) ? 32'd1 : 32'd0);
            if (i <= 9) begin
                chk($sformatf("sweep.idx@%0d", i), 32'(entry_idx),
                    (i <= 5) ? 32'd0 : ((i <= 8) ? 32'd1 : 32'd2));
            end
            step();
        end

        // Looping two-entry sweep, then abort mid-run.
        wr(3'd0, 32'd10, 24'd2);
        wr(3'd1, 32'd20, 24'd2);
        go(4'd2, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("loop.pinc@%0d", i), pinc_out, (((i - 1) % 4) < 2) ? 32'd10 : 32'd20);
            chk($sformatf("loop.done@%0d", i), 32'(done), 32'd0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort.pinc", pinc_out, 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.vld",  32'(pinc_vld), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        step();
        chk("abort.done_after", 32'(done), 32'd0);
        chk("abort.busy_after", 32'(busy), 32'd0);

        // Zero dwell holds for one cycle.
        wr(3'd0, 32'd55, 24'd0);
        wr(3'd1, 32'd66, 24'd2);
        go(4'd2, 1'b0);
        chk("dw0.pinc@1", pinc_out, 32'd55);
        step();
        chk("dw0.pinc@2", pinc_out, 32'd66);
        chk("dw0.vld@2",  32'(pinc_vld), 32'd1);
        step();
        chk("dw0.pinc@3", pinc_out, 32'd66);
        step();
        chk("dw0.pinc@4", pinc_out, 32'd0);
        chk("dw0.done@4", 32'(done), 32'd1);
        step();
`endif

        // Empty sweep: done next cycle, busy never rises.
        go(4'd0, 1'b0);
        chk("n0.done", 32'(done), 32'd1);
        chk("n0.busy", 32'(busy), 32'd0);
        chk("n0.pinc", pinc_out, 32'd0);
        step();
        chk("n0.done_after", 32'(done), 32'd0);
        chk("n0.busy_after", 32'(busy), 32'd0);

        // Start and abort together leave the controller idle.
        num_entries = 4'd1;
        start       = 1'b1;
        abort       = 1'b1;
        step();
        start       = 1'b0;
        abort       = 1'b0;
        chk("sa.busy", 32'(busy), 32'd0);
        chk("sa.pinc", pinc_out, 32'd0);
        chk("sa.vld",  32'(pinc_vld), 32'd0);
        step();
        chk("sa.busy_after", 32'(busy), 32'd0);

`ifndef CFO_SWEEP_RAMP_EN
        // Writes while busy are dropped; a write at W is seen by a start at W+1.
        wr(3'd0, 32'd77, 24'd3);
        go(4'd1, 1'b0);
        wr(3'd0, 32'd88, 24'd3);
        step();
        step();
        step();
        chk("prot.idle", 32'(busy), 32'd0);
        go(4'd1, 1'b0);
        chk("prot.old_value", pinc_out, 32'd77);
        for (int i = 0; i < 4; i++) step();
        wr(3'd0, 32'd99, 24'd2);
        go(4'd1, 1'b0);
        chk("prot.new_value", pinc_out, 32'd99);
        for (int i = 0; i < 3; i++) step();
`endif

        // Reset in the middle of a dwell, then a fresh sweep.
        go(4'd1, 1'b0);
        step();
        chk("rmid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk("rmid.pinc", pinc_out, 32'd0);
        chk("rmid.vld",  32'(pinc_vld), 32'd0);
        chk("rmid.idx",  32'(entry_idx), 32'd0);
        chk("rmid.busy", 32'(busy), 32'd0);
        chk("rmid.done", 32'(done), 32'd0);
        reset = 1'b0;
        step();
        go(4'd1, 1'b0);
        chk("rmid.restart_busy", 32'(busy), 32'd1);
        chk("rmid.restart_vld",  32'(pinc_vld), 32'd1);
        for (int i = 0; i < 12; i++) step();
        chk("rmid.final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
